// File: rtl/result_display_seq_pkg.sv
// Shared definitions for the result display sequencer.
//   - DEFAULT_DATA_W : default element width
//   - ST_IDLE        : state_o code reported while idle (DONE code is
//                      NUM_GROUPS+1, derived inside the module)
//   - fsm_e          : internal FSM encoding
//   - width_of()     : clog2-style width helper, never returns less than 1
package result_display_seq_pkg;

   localparam int DEFAULT_DATA_W = 8;
   localparam int ST_IDLE        = 0;

   typedef enum logic [1:0] {
      FSM_IDLE = 2'd0,
      FSM_SHOW = 2'd1,
      FSM_DONE = 2'd2
   } fsm_e;

   // Bits needed to index n items; a single item still gets one bit.
   function automatic int width_of(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/result_display_seq_if.sv
// Display port bundle between the sequencer and the display driver.
//   disp_data  : element currently presented
//   disp_valid : disp_data is stable and may be consumed
//   disp_ready : consumer accepts the element when high with disp_valid
//   disp_group : group index of the presented element
//   disp_index : element index within the group
// master = sequencer side, slave = display driver side.
interface result_display_seq_if
   import result_display_seq_pkg::*;
#(
   parameter int DATA_W  = DEFAULT_DATA_W,
   parameter int GROUP_W = 2,
   parameter int INDEX_W = 2
);

   logic [DATA_W-1:0]  disp_data;
   logic               disp_valid;
   logic               disp_ready;
   logic [GROUP_W-1:0] disp_group;
   logic [INDEX_W-1:0] disp_index;

   modport master (
      output disp_data, disp_valid, disp_group, disp_index,
      input  disp_ready
   );

   modport slave (
      input  disp_data, disp_valid, disp_group, disp_index,
      output disp_ready
   );

endinterface

// File: rtl/result_display_seq_dwell_timer.sv
// display_dwell_timer: loadable down-counter with a zero flag.
//   clk, reset   : clock, asynchronous active-high reset (count -> 0)
//   load_i       : load load_val_i this edge (takes priority over counting)
//   load_val_i   : value to load
//   zero_o       : count is zero
// Counts down by one per cycle and parks at zero.
module display_dwell_timer #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)               cnt_q <= '0;
      else if (load_i)         cnt_q <= load_val_i;
      else if (cnt_q != '0)    cnt_q <= cnt_q - W'(1);
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/result_display_seq.sv
// result_display_seq: snapshots NUM_GROUPS x ELEMS result elements on a start
// pulse, then presents them one by one on a valid/ready display port, each
// held for at least HOLD_CYCLES cycles before valid rises.
//   clk, reset  : clock, asynchronous active-high reset
//   start_i     : capture data_i and begin display (ignored while busy)
//   data_i      : flattened results, (g,e) at [(g*ELEMS+e)*DATA_W +: DATA_W]
//   stop_i      : (RESULT_DISPLAY_LOOP_EN only) end the looping display
//   disp        : display port (master side of result_display_seq_if)
//   state_o     : 0 idle, g+1 showing group g, NUM_GROUPS+1 done
//   busy_o      : high outside idle
//   done_o      : one-cycle pulse after the final element
// Optional macro RESULT_DISPLAY_LOOP_EN: the display wraps to (0,0) after the
// last element instead of finishing, and stop_i ends it.
// Every output comes straight from a flop, so disp_ready has no
// combinational path to any output.
module result_display_seq
   import result_display_seq_pkg::*;
#(
   parameter int DATA_W      = DEFAULT_DATA_W,
   parameter int ELEMS       = 4,
   parameter int NUM_GROUPS  = 3,
   parameter int HOLD_CYCLES = 1
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic                                  start_i,
   input  logic [NUM_GROUPS*ELEMS*DATA_W-1:0]    data_i,
`ifdef RESULT_DISPLAY_LOOP_EN
   input  logic                                  stop_i,
`endif
   result_display_seq_if.master                  disp,
   output logic [width_of(NUM_GROUPS+2)-1:0]     state_o,
   output logic                                  busy_o,
   output logic                                  done_o
);

   localparam int GROUP_W = width_of(NUM_GROUPS);
   localparam int INDEX_W = width_of(ELEMS);
   localparam int STATE_W = width_of(NUM_GROUPS + 2);
   localparam int DWELL_W = width_of(HOLD_CYCLES);
   localparam int ST_DONE = NUM_GROUPS + 1;

   localparam logic [GROUP_W-1:0] LAST_G     = GROUP_W'(NUM_GROUPS - 1);
   localparam logic [INDEX_W-1:0] LAST_E     = INDEX_W'(ELEMS - 1);
   localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(HOLD_CYCLES - 1);

   // Packed so that the flat data_i layout maps onto [group][elem] directly.
   logic [NUM_GROUPS-1:0][ELEMS-1:0][DATA_W-1:0] mem_q;

   fsm_e               fsm_q, fsm_d;
   logic [GROUP_W-1:0] grp_q, grp_d;
   logic [INDEX_W-1:0] idx_q, idx_d;
   logic [DATA_W-1:0]  data_q, data_d;
   logic               valid_q, valid_d;
   logic               done_q, done_d;
   logic               busy_q, busy_d;
   logic [STATE_W-1:0] scode_q, scode_d;
   logic               cap_en;
   logic               dwell_ld;
   logic               dwell_zero;
   logic               xfer;

   display_dwell_timer #(.W(DWELL_W)) u_dwell (
      .clk        (clk),
      .reset      (reset),
      .load_i     (dwell_ld),
      .load_val_i (DWELL_LOAD),
      .zero_o     (dwell_zero)
   );

   assign xfer = valid_q & disp.disp_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)       mem_q <= '0;
      else if (cap_en) mem_q <= data_i;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fsm_q   <= FSM_IDLE;
         grp_q   <= '0;
         idx_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         scode_q <= '0;
      end else begin
         fsm_q   <= fsm_d;
         grp_q   <= grp_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         scode_q <= scode_d;
      end
   end

   always_comb begin
      fsm_d    = fsm_q;
      grp_d    = grp_q;
      idx_d    = idx_q;
      data_d   = data_q;
      valid_d  = valid_q;
      done_d   = 1'b0;
      cap_en   = 1'b0;
      dwell_ld = 1'b0;

      unique case (fsm_q)
         FSM_IDLE: begin
            valid_d = 1'b0;
            if (start_i) begin
               cap_en   = 1'b1;
               grp_d    = '0;
               idx_d    = '0;
               // Memory is written on this same edge, so take (0,0) from the bus.
               data_d   = data_i[DATA_W-1:0];
               dwell_ld = 1'b1;
               fsm_d    = FSM_SHOW;
            end
         end

         FSM_SHOW: begin
`ifdef RESULT_DISPLAY_LOOP_EN
            if (stop_i) begin
               // Pending element is dropped without a transfer.
               fsm_d   = FSM_DONE;
               valid_d = 1'b0;
               done_d  = 1'b1;
            end else
`endif
            if (xfer) begin
               // Valid always drops for a cycle after a transfer.
               valid_d  = 1'b0;
               dwell_ld = 1'b1;
               if (idx_q != LAST_E) begin
                  idx_d = idx_q + INDEX_W'(1);
               end else if (grp_q != LAST_G) begin
                  idx_d = '0;
                  grp_d = grp_q + GROUP_W'(1);
               end else begin
`ifdef RESULT_DISPLAY_LOOP_EN
                  idx_d = '0;
                  grp_d = '0;
`else
                  fsm_d  = FSM_DONE;
                  done_d = 1'b1;
`endif
               end
               // On finishing, the last element stays on the port.
               if (fsm_d == FSM_SHOW) data_d = mem_q[grp_d][idx_d];
            end else if (!valid_q) begin
               valid_d = dwell_zero;
            end
         end

         FSM_DONE: begin
            fsm_d   = FSM_IDLE;
            valid_d = 1'b0;
         end

         default: fsm_d = FSM_IDLE;
      endcase

      busy_d = (fsm_d != FSM_IDLE);
      unique case (fsm_d)
         FSM_SHOW: scode_d = STATE_W'(grp_d) + STATE_W'(1);
         FSM_DONE: scode_d = STATE_W'(ST_DONE);
         default:  scode_d = STATE_W'(ST_IDLE);
      endcase
   end

   assign disp.disp_data  = data_q;
   assign disp.disp_valid = valid_q;
   assign disp.disp_group = grp_q;
   assign disp.disp_index = idx_q;
   assign state_o         = scode_q;
   assign busy_o          = busy_q;
   assign done_o          = done_q;

endmodule

// File: tb/tb_result_display_seq.sv
// Directed bench for result_display_seq: one instance with HOLD_CYCLES=1
// (handshake, backpressure, restart, reset) and one with HOLD_CYCLES=3
// (dwell timing). RESULT_DISPLAY_LOOP_EN selects the looping scenario.
module tb_result_display_seq;
   import result_display_seq_pkg::*;

   localparam int DW = 8;
   localparam int NE = 4;
   localparam int NG = 3;
   localparam int GW = width_of(NG);
   localparam int IW = width_of(NE);
   localparam int SW = width_of(NG + 2);

   logic              clk = 1'b0;
   logic              reset;
   logic              start, start3;
   logic [NG*NE*DW-1:0] data;
   logic [SW-1:0]     state, state3;
   logic              busy, busy3, done, done3;
`ifdef RESULT_DISPLAY_LOOP_EN
   logic              stop;
   logic              stop3;
`endif

   int n_cmp = 0;
   int n_err = 0;

   result_display_seq_if #(.DATA_W(DW), .GROUP_W(GW), .INDEX_W(IW)) dif ();
   result_display_seq_if #(.DATA_W(DW), .GROUP_W(GW), .INDEX_W(IW)) dif3 ();

   always #5 clk = ~clk;

   assign dif3.disp_ready = 1'b1;

   result_display_seq #(.DATA_W(DW), .ELEMS(NE), .NUM_GROUPS(NG), .HOLD_CYCLES(1)) dut (
      .clk     (clk),
      .reset   (reset),
      .start_i (start),
      .data_i  (data),
`ifdef RESULT_DISPLAY_LOOP_EN
      .stop_i  (stop),
`endif
      .disp    (dif),
      .state_o (state),
      .busy_o  (busy),
      .done_o  (done)
   );

   result_display_seq #(.DATA_W(DW), .ELEMS(NE), .NUM_GROUPS(NG), .HOLD_CYCLES(3)) dut3 (
      .clk     (clk),
      .reset   (reset),
      .start_i (start3),
      .data_i  (data),
`ifdef RESULT_DISPLAY_LOOP_EN
      .stop_i  (stop3),
`endif
      .disp    (dif3),
      .state_o (state3),
      .busy_o  (busy3),
      .done_o  (done3)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Element k = base + k, packed with element 0 at the bottom.
   task automatic set_data(input int base);
      data = '0;
      for (int k = NG*NE-1; k >= 0; k--)
         data = {data[NG*NE*DW-DW-1:0], 8'(base + k)};
   endtask

   task automatic start_run(input int base);
      set_data(base);
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // One full pass on dut with ready high, optional 5-cycle stall on element
   // (1,2) and optional second start at cycle 6 with other data.
   task automatic run_pass(input int base, input bit bp, input bit mid_start, input int exp_len);
      int n = 0;
      int c = 0;
      bit fin = 0;
      bit bp_done = 0;
      dif.disp_ready = 1'b1;
      start_run(base);
      while (!fin && c < 300) begin
         if (mid_start && c == 6) begin
            set_data(base + 8'h80);
            start = 1'b1;
         end else begin
            start = 1'b0;
         end
         if (bp && !bp_done && dif.disp_valid && dif.disp_group == 1 && dif.disp_index == 2) begin
            for (int i = 0; i < 5; i++) begin
               dif.disp_ready = 1'b0;
               chk("bp_valid", dif.disp_valid, 1);
               chk("bp_data",  dif.disp_data, base + 6);
               chk("bp_group", dif.disp_group, 1);
               chk("bp_index", dif.disp_index, 2);
               tick();
               c++;
            end
            dif.disp_ready = 1'b1;
            bp_done = 1;
         end
         if (dif.disp_valid && dif.disp_ready) begin
            chk("xfer_data",  dif.disp_data, base + n);
            chk("xfer_group", dif.disp_group, n / NE);
            chk("xfer_index", dif.disp_index, n % NE);
            chk("xfer_state", state, n / NE + 1);
            chk("xfer_busy",  busy, 1);
            n++;
         end
         if (done) begin
            chk("done_state", state, NG + 1);
            chk("done_count", n, NG * NE);
            chk("run_len", c, exp_len);
            fin = 1;
         end else begin
            tick();
            c++;
         end
      end
      start = 1'b0;
      if (!fin) chk("run_timeout", 0, 1);
      tick();
      chk("post_done", done, 0);
      chk("post_busy", busy, 0);
      chk("post_state", state, 0);
      chk("post_valid", dif.disp_valid, 0);
   endtask

   initial begin
      int c;
      int vcount;
      int perr;
      int donec;
      int dseen;

      reset          = 1'b1;
      start          = 1'b0;
      start3         = 1'b0;
      dif.disp_ready = 1'b1;
      data           = '0;
`ifdef RESULT_DISPLAY_LOOP_EN
      stop           = 1'b0;
      stop3          = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      chk("rst_data",  dif.disp_data, 0);
      chk("rst_valid", dif.disp_valid, 0);
      chk("rst_group", dif.disp_group, 0);
      chk("rst_index", dif.disp_index, 0);
      chk("rst_state", state, 0);
      chk("rst_busy",  busy, 0);
      chk("rst_done",  done, 0);
      reset = 1'b0;
      tick();

`ifdef RESULT_DISPLAY_LOOP_EN
      // Loop: after element 12 the display wraps to (0,0); stop ends it.
      dif.disp_ready = 1'b1;
      start_run(1);
      vcount = 0;
      c      = 0;
      while (vcount < 13 && c < 100) begin
         if (dif.disp_valid && dif.disp_ready) begin
            if (vcount == 11) chk("loop_last", dif.disp_data, 8'h0C);
            if (vcount == 12) begin
               chk("loop_wrap_data",  dif.disp_data, 8'h01);
               chk("loop_wrap_group", dif.disp_group, 0);
               chk("loop_wrap_index", dif.disp_index, 0);
            end
            vcount++;
         end
         chk("loop_no_done", done, 0);
         tick();
         c++;
      end
      chk("loop_reached", vcount, 13);
      c = 0;
      while (dif.disp_group != 2 && c < 100) begin
         tick();
         c++;
      end
      chk("loop_group2", dif.disp_group, 2);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("stop_done",  done, 1);
      chk("stop_state", state, NG + 1);
      chk("stop_valid", dif.disp_valid, 0);
      tick();
      chk("stop_idle",  state, 0);
      chk("stop_busy",  busy, 0);
      chk("stop_pulse", done, 0);
`else
      // HOLD_CYCLES=3: element k valid only at cycle 4k+3, done at cycle 48.
      set_data(1);
      start3 = 1'b1;
      tick();
      start3 = 1'b0;
      c      = 0;
      vcount = 0;
      perr   = 0;
      donec  = -1;
      while (donec < 0 && c < 80) begin
         if (done3) begin
            donec = c;
         end else begin
            if (dif3.disp_valid !== ((c % 4) == 3)) perr++;
            if (dif3.disp_valid) begin
               if (dif3.disp_data !== 8'(1 + vcount)) perr++;
               vcount++;
            end
            tick();
            c++;
         end
      end
      chk("h3_pattern", perr, 0);
      chk("h3_valid_count", vcount, 12);
      chk("h3_len", donec, 48);
      chk("h3_done_state", state3, NG + 1);
      tick();
      chk("h3_idle", busy3, 0);

      // Plain pass, backpressure, ignored mid-run start, then fresh capture.
      run_pass(8'h01, 0, 0, 24);
      run_pass(8'h01, 1, 0, 29);
      run_pass(8'h21, 0, 1, 24);
      run_pass(8'h41, 0, 0, 24);

      // Reset during group 1 clears outputs at once and produces no done.
      dif.disp_ready = 1'b1;
      start_run(1);
      c = 0;
      while (dif.disp_group != 1 && c < 50) begin
         tick();
         c++;
      end
      chk("rst_mid_reach", dif.disp_group, 1);
      #2 reset = 1'b1;
      #1;
      chk("arst_data",  dif.disp_data, 0);
      chk("arst_valid", dif.disp_valid, 0);
      chk("arst_group", dif.disp_group, 0);
      chk("arst_index", dif.disp_index, 0);
      chk("arst_state", state, 0);
      chk("arst_busy",  busy, 0);
      dseen = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (done) dseen++;
      end
      reset = 1'b0;
      tick();
      if (done) dseen++;
      chk("arst_no_done", dseen, 0);
      run_pass(8'h01, 0, 0, 24);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
